mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: aluop  in  OpCodeLen  op from EX latch (EX_LB/LH/LW/LBU/LHU/SB/SH/SW, MEM_NOP).
REQ-004 SHALL have ports: rd_addr / rd_enable  in  5 / 1  destination from EX latch.
REQ-005 SHALL have ports: data_in  in  32  ALU result (non-memory ops) or store data.
REQ-006 SHALL have ports: mem_addr_in  in  32  effective byte address.
REQ-007 SHALL have ports: ram_req / ram_we  out  1 / 1  byte request, write enable.
REQ-008 SHALL have ports: ram_addr  out  32;  ram_wdata  out  8;  ram_rdata  in  8;  ram_ready  in  1  (byte completes on the cycle ram_ready is high).
REQ-009 SHALL have ports: rd_addr_o / rd_enable_o / rd_data_o  out  5 / 1 / 32  writeback result.
REQ-010 SHALL have ports: stall_req  out  1  hold upstream stages;  misalign  out  1  (only with MEM_ALIGN_CHECK_EN).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-012 SHALL, in IDLE with a non-memory aluop, pass data_in/rd_addr/rd_enable combinationally to outputs, with stall_req=0.
REQ-013 SHALL, in IDLE with a load/store aluop, latch op/addr/data/rd, set byte count N (B=1, H=2, W=4), clear byte index, enter ACCESS, and assert stall_req the same cycle.
REQ-014 SHALL, in ACCESS, drive ram_req=1, ram_addr=base+index, ram_we=1 for stores, and ram_wdata=store_data[8*index+7:8*index] (little-endian).
REQ-015 SHALL advance index only on ram_ready; on loads, capture ram_rdata into byte[index].
REQ-016 SHALL move ACCESS->DONE on ram_ready with index==N-1.
REQ-017 SHALL, in DONE, drive rd_data_o=extended load value (LB/LH sign-extend; LBU/LHU zero-extend; LW full), rd_enable_o=latched rd_enable for loads and 0 for stores, stall_req=0, ram_req=0; next state IDLE.
REQ-018 SHALL keep stall_req high in every ACCESS cycle, including ram_ready stall cycles.
REQ-019 SHALL hold ram_addr/ram_wdata stable while ram_req=1 and ram_ready=0.
REQ-020 SHALL set latency to N ready-cycles + 1 DONE cycle; with ram_ready always high, LW = 5 cycles from accept to writeback.
REQ-021 SHALL force rd_enable_o=0 when rd_addr_o==0.
REQ-022 SHALL compute address as 32-bit wrap-around: base 0xFFFFFFFF + 1 -> 0x00000000.
REQ-023 SHALL ignore aluop changes outside IDLE, because the operands are latched.

Reset
REQ-024 SHALL, while rst=0 and regardless of clk, put the state in IDLE and drive ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, stall_req=0, rd_enable_o=0, rd_addr_o=0, rd_data_o=0, misalign=0.
REQ-025 SHALL abandon an in-flight access on reset mid-ACCESS with no writeback; bytes already stored stay written.

Configuration
REQ-026 SHALL, with MEM_ALIGN_CHECK_EN defined, detect misaligned LH/LHU/SH (addr[0]) and LW/SW (addr[1:0]!=0) in IDLE, issue no ram_req, pulse misalign=1 for one cycle, and force rd_enable_o=0 and stall_req=0.
REQ-027 SHALL, with MEM_ALIGN_CHECK_EN undefined, perform misaligned accesses byte-serially like aligned ones and tie misalign to 0.

Structure
REQ-028 SHALL take aluop codes (EX_*/MEM_NOP), OpCodeLen, and FSM state encoding from the shared defines package.
REQ-029 SHALL use one sub-module, mem_load_ext: combinational 32-bit sign/zero extender selected by the op.

Verification
REQ-030 SHALL verify LW @0x100, bytes 0x78,0x56,0x34,0x12, ram_ready always 1 -> ram_addr 0x100..0x103, rd_data_o=0x12345678 in cycle 5, stall_req high for cycles 1-4.
REQ-031 SHALL verify LB @0x20, byte 0x80 -> rd_data_o=0xFFFFFF80; LBU of the same byte -> 0x00000080.
REQ-032 SHALL verify SH @0x40, data 0xDEADBEEF, ram_ready low for 2 cycles on byte 0 -> writes 0xEF@0x40 then 0xBE@0x41, address held during wait, rd_enable_o=0 at DONE.
REQ-033 SHALL verify EX_ADD result 0x5, rd=3 -> same-cycle rd_data_o=5, rd_enable_o=1, stall_req=0; rd=0 -> rd_enable_o=0.
REQ-034 SHALL verify rst dropped during byte 2 of LW -> ram_req=0 immediately, no writeback, next LW completes normally.
REQ-035 SHALL verify, with MEM_ALIGN_CHECK_EN, LW @0x102 -> misalign=1 for one cycle and no ram_req; without it, LW @0x102 -> bytes 0x102..0x105 accessed.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared defines for the MEM pipeline stage: opcode width and codes, the
// stage FSM encoding, and small opcode-decoding helpers used by the stage
// and by its load extender.
package mem_stage_pkg;

  localparam int OpCodeLen = 6;

  typedef logic [OpCodeLen-1:0] opcode_t;

  // Non-memory operations; their ALU result simply flows through MEM.
  localparam opcode_t MEM_NOP = 6'h00;
  localparam opcode_t EX_ADD  = 6'h01;
  localparam opcode_t EX_SUB  = 6'h02;
  localparam opcode_t EX_AND  = 6'h03;
  localparam opcode_t EX_OR   = 6'h04;
  localparam opcode_t EX_XOR  = 6'h05;

  // Loads.
  localparam opcode_t EX_LB   = 6'h10;
  localparam opcode_t EX_LH   = 6'h11;
  localparam opcode_t EX_LW   = 6'h12;
  localparam opcode_t EX_LBU  = 6'h13;
  localparam opcode_t EX_LHU  = 6'h14;

  // Stores.
  localparam opcode_t EX_SB   = 6'h18;
  localparam opcode_t EX_SH   = 6'h19;
  localparam opcode_t EX_SW   = 6'h1A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  function automatic logic is_load(input opcode_t op);
    return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
           (op == EX_LBU) || (op == EX_LHU);
  endfunction

  function automatic logic is_store(input opcode_t op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  function automatic logic is_mem_op(input opcode_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Number of bytes moved by a memory op (B=1, H=2, W=4).
  function automatic logic [2:0] op_nbytes(input opcode_t op);
    logic [2:0] n;
    case (op)
      EX_LH, EX_LHU, EX_SH: n = 3'd2;
      EX_LW, EX_SW:         n = 3'd4;
      default:              n = 3'd1;
    endcase
    return n;
  endfunction

  // Natural-alignment test on the two low address bits.
  function automatic logic is_misaligned(input opcode_t op, input logic [1:0] addr_lo);
    logic bad;
    case (op)
      EX_LH, EX_LHU, EX_SH: bad = addr_lo[0];
      EX_LW, EX_SW:         bad = (addr_lo != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load extender: turns the assembled little-endian load bytes into the
// 32-bit writeback value (sign-extend LB/LH, zero-extend LBU/LHU, LW as is).
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  opcode_t     op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  // Select the extension mode from the latched load opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    data_o = raw_i;
    case (op_i)
      EX_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      EX_LBU:  data_o = {24'd0, raw_i[7:0]};
      EX_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      EX_LHU:  data_o = {16'd0, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with a byte-serial RAM port. Non-memory ops pass
// straight through; loads and stores are latched in IDLE, moved one byte per
// ram_ready in ACCESS (little-endian, address = base + index, 32-bit wrap),
// and written back for one cycle in DONE. Upstream is stalled from the
// accept cycle through the last ACCESS cycle.
// Optional build macro: MEM_ALIGN_CHECK_EN -- rejects misaligned half/word
// accesses in IDLE with a one-cycle misalign flag instead of performing them.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active low
  input  logic [OpCodeLen-1:0] aluop,
  input  logic [4:0]           rd_addr,
  input  logic                 rd_enable,
  input  logic [31:0]          data_in,
  input  logic [31:0]          mem_addr_in,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [31:0]          ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  input  logic                 ram_ready,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_enable_o,
  output logic [31:0]          rd_data_o,
  output logic                 stall_req,
  output logic                 misalign
);

  mem_state_e       state_q, state_d;
  opcode_t          op_q, op_d;
  logic [31:0]      base_q, base_d;
  logic [3:0][7:0]  data_q, data_d;    // store data, byte lanes
  logic [3:0][7:0]  bytes_q, bytes_d;  // assembled load bytes
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             rd_en_q, rd_en_d;
  logic [2:0]       cnt_q, cnt_d;      // bytes in this access (1, 2 or 4)
  logic [1:0]       idx_q, idx_d;      // byte currently on the RAM port

  logic [31:0]      ext_data;
  logic             misaligned_w;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_w = is_misaligned(aluop, mem_addr_in[1:0]);
`else
  // Misaligned accesses are simply performed byte by byte.
  assign misaligned_w = 1'b0;
`endif

  mem_load_ext u_load_ext (
    .op_i   (op_q),
    .raw_i  (bytes_q),
    .data_o (ext_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same edge, independent of order.
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched operands, byte counter/index and load byte buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= MEM_NOP;
      base_q    <= '0;
      data_q    <= '0;
      bytes_q   <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      op_q      <= op_d;
      base_q    <= base_d;
      data_q    <= data_d;
      bytes_q   <= bytes_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state, datapath next values and all stage outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    data_d      = data_q;
    bytes_d     = bytes_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = rd_en_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;

    ram_req     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    rd_addr_o   = '0;
    rd_enable_o = 1'b0;
    rd_data_o   = '0;
    stall_req   = 1'b0;
    misalign    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!is_mem_op(aluop)) begin
          // ALU result flows through in the same cycle.
          rd_addr_o   = rd_addr;
          rd_enable_o = rd_enable;
          rd_data_o   = data_in;
        end else if (misaligned_w) begin
          // Rejected access: flag it, no RAM traffic, no stall, no writeback.
          misalign = 1'b1;
        end else begin
          // Accept: latch everything so later aluop changes are ignored.
          op_d      = aluop;
          base_d    = mem_addr_in;
          data_d    = data_in;
          bytes_d   = '0;
          rd_addr_d = rd_addr;
          rd_en_d   = rd_enable;
          cnt_d     = op_nbytes(aluop);
          idx_d     = '0;
          stall_req = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Address and write data depend only on latched state, so they stay
        // stable while the RAM holds ram_ready low.
        ram_req   = 1'b1;
        ram_we    = is_store(op_q);
        ram_addr  = base_q + {30'd0, idx_q};
        ram_wdata = data_q[idx_q];
        stall_req = 1'b1;
        if (ram_ready) begin
          if (is_load(op_q)) begin
            bytes_d[idx_q] = ram_rdata;
          end
          if ({1'b0, idx_q} == (cnt_q - 3'd1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_DONE: begin
        rd_addr_o   = rd_addr_q;
        rd_enable_o = is_load(op_q) && rd_en_q;
        rd_data_o   = is_load(op_q) ? ext_data : 32'd0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Register x0 is never written.
    if (rd_addr_o == 5'd0) begin
      rd_enable_o = 1'b0;
    end

    // Outputs are held quiet for as long as reset is asserted, including the
    // combinational pass-through path.
    if (!rst) begin
      ram_req     = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      rd_addr_o   = '0;
      rd_enable_o = 1'b0;
      rd_data_o   = '0;
      stall_req   = 1'b0;
      misalign    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a byte-wide RAM model and a
// scoreboard of expected RAM transactions and writeback values.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [OpCodeLen-1:0] aluop;
  logic [4:0]           rd_addr;
  logic                 rd_enable;
  logic [31:0]          data_in;
  logic [31:0]          mem_addr_in;
  logic                 ram_req;
  logic                 ram_we;
  logic [31:0]          ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
  logic                 ram_ready;
  logic [4:0]           rd_addr_o;
  logic                 rd_enable_o;
  logic [31:0]          rd_data_o;
  logic                 stall_req;
  logic                 misalign;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        chk_wdata;
  } ram_exp_t;

  ram_exp_t    exp_q[$];
  logic [31:0] wb_q[$];

  logic [7:0]  mem [0:1023];

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop       (aluop),
    .rd_addr     (rd_addr),
    .rd_enable   (rd_enable),
    .data_in     (data_in),
    .mem_addr_in (mem_addr_in),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready),
    .rd_addr_o   (rd_addr_o),
    .rd_enable_o (rd_enable_o),
    .rd_data_o   (rd_data_o),
    .stall_req   (stall_req),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[9:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RAM side: every completing byte is matched against the scoreboard and
  // stores are committed to the model memory.
  always @(negedge clk) begin : ram_monitor
    ram_exp_t e;
    if (rst && ram_req && ram_ready) begin
      if (exp_q.size() == 0) begin
        check("ram_unexpected_req", {31'd0, ram_req}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ram_addr", ram_addr, e.addr);
        check("ram_we", {31'd0, ram_we}, {31'd0, e.we});
        if (e.chk_wdata) check("ram_wdata", {24'd0, ram_wdata}, {24'd0, e.wdata});
      end
      if (ram_we) mem[ram_addr[9:0]] = ram_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    aluop       = MEM_NOP;
    rd_addr     = 5'd0;
    rd_enable   = 1'b0;
    data_in     = 32'd0;
    mem_addr_in = 32'd0;
  endtask

  task automatic push_bytes(input logic [31:0] addr, input logic [31:0] data,
                            input int n, input logic we);
    ram_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr      = addr + 32'(i);
      e.we        = we;
      e.wdata     = data[8*i +: 8];
      e.chk_wdata = we;
      exp_q.push_back(e);
    end
  endtask

  // One memory op with ram_ready held high: accept, n ACCESS cycles, DONE.
  // The op inputs are scrambled during ACCESS to show they are ignored.
  task automatic do_mem(input opcode_t op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int n, input logic we,
                        input logic [31:0] exp_data, input logic exp_en, input string tag);
    push_bytes(addr, data, n, we);
    wb_q.push_back(exp_data);
    aluop = op; mem_addr_in = addr; data_in = data; rd_addr = rd; rd_enable = 1'b1;
    ram_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept_stall"}, {31'd0, stall_req}, 32'd1);
    check({tag, "_accept_noreq"}, {31'd0, ram_req}, 32'd0);
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      aluop = EX_SB; mem_addr_in = 32'h0000_0999; data_in = 32'h0000_0BAD;
      @(negedge clk);
      check({tag, "_access_stall"}, {31'd0, stall_req}, 32'd1);
      check({tag, "_access_req"}, {31'd0, ram_req}, 32'd1);
    end
    next_cycle();
    idle_in();
    @(negedge clk);
    check({tag, "_done_data"}, rd_data_o, wb_q.pop_front());
    check({tag, "_done_en"}, {31'd0, rd_enable_o}, {31'd0, exp_en});
    check({tag, "_done_rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    check({tag, "_done_stall"}, {31'd0, stall_req}, 32'd0);
    check({tag, "_done_noreq"}, {31'd0, ram_req}, 32'd0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h104] = 8'hA5; mem[10'h105] = 8'h5A;
    mem[10'h020] = 8'h80;

    // Reset with a live pass-through op on the inputs: outputs must be quiet.
    rst = 1'b0; ram_ready = 1'b1;
    aluop = EX_ADD; data_in = 32'h0000_CAFE; rd_addr = 5'd3; rd_enable = 1'b1;
    mem_addr_in = 32'd0;
    @(negedge clk);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_rd_en", {31'd0, rd_enable_o}, 32'd0);
    check("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_req", {31'd0, ram_req}, 32'd0);
    next_cycle();
    rst = 1'b1;
    idle_in();
    next_cycle();

    // ALU pass-through, same cycle.
    aluop = EX_ADD; data_in = 32'd5; rd_addr = 5'd3; rd_enable = 1'b1;
    #1;
    check("add_data", rd_data_o, 32'd5);
    check("add_en", {31'd0, rd_enable_o}, 32'd1);
    check("add_stall", {31'd0, stall_req}, 32'd0);
    check("add_noreq", {31'd0, ram_req}, 32'd0);
    rd_addr = 5'd0;
    #1;
    check("add_x0_en", {31'd0, rd_enable_o}, 32'd0);
    next_cycle();
    idle_in();

    // LW @0x100 with ram_ready always high: writeback in cycle 5.
    do_mem(EX_LW, 32'h0000_0100, 32'd0, 5'd5, 4, 1'b0, 32'h1234_5678, 1'b1, "lw");

    // LB / LBU of 0x80.
    do_mem(EX_LB, 32'h0000_0020, 32'd0, 5'd6, 1, 1'b0, 32'hFFFF_FF80, 1'b1, "lb");
    do_mem(EX_LBU, 32'h0000_0020, 32'd0, 5'd6, 1, 1'b0, 32'h0000_0080, 1'b1, "lbu");

    // SH @0x40 with two wait cycles on byte 0.
    push_bytes(32'h0000_0040, 32'hDEAD_BEEF, 2, 1'b1);
    aluop = EX_SH; mem_addr_in = 32'h0000_0040; data_in = 32'hDEAD_BEEF;
    rd_addr = 5'd7; rd_enable = 1'b1; ram_ready = 1'b1;
    @(negedge clk);
    check("sh_accept_stall", {31'd0, stall_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_in();
      ram_ready = (i == 2);
      @(negedge clk);
      check("sh_wait_addr", ram_addr, 32'h0000_0040);
      check("sh_wait_wdata", {24'd0, ram_wdata}, 32'h0000_00EF);
      check("sh_wait_we", {31'd0, ram_we}, 32'd1);
      check("sh_wait_stall", {31'd0, stall_req}, 32'd1);
    end
    next_cycle();
    @(negedge clk);
    check("sh_b1_addr", ram_addr, 32'h0000_0041);
    check("sh_b1_wdata", {24'd0, ram_wdata}, 32'h0000_00BE);
    next_cycle();
    @(negedge clk);
    check("sh_done_en", {31'd0, rd_enable_o}, 32'd0);
    check("sh_done_stall", {31'd0, stall_req}, 32'd0);
    check("sh_done_noreq", {31'd0, ram_req}, 32'd0);
    check("sh_mem40", {24'd0, mem[10'h040]}, 32'h0000_00EF);
    check("sh_mem41", {24'd0, mem[10'h041]}, 32'h0000_00BE);
    next_cycle();

    // Reset dropped while byte 2 of an LW is on the port.
    push_bytes(32'h0000_0100, 32'd0, 2, 1'b0);
    aluop = EX_LW; mem_addr_in = 32'h0000_0100; rd_addr = 5'd5; rd_enable = 1'b1;
    ram_ready = 1'b1;
    next_cycle();
    idle_in();
    next_cycle();
    next_cycle();
    check("rstmid_byte2_addr", ram_addr, 32'h0000_0102);
    check("rstmid_byte2_req", {31'd0, ram_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid_req", {31'd0, ram_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall_req}, 32'd0);
    check("rstmid_en", {31'd0, rd_enable_o}, 32'd0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstmid_no_wb", {31'd0, rd_enable_o}, 32'd0);
      check("rstmid_idle_req", {31'd0, ram_req}, 32'd0);
      next_cycle();
    end
    do_mem(EX_LW, 32'h0000_0100, 32'd0, 5'd5, 4, 1'b0, 32'h1234_5678, 1'b1, "lw_after_rst");

`ifdef MEM_ALIGN_CHECK_EN
    aluop = EX_LW; mem_addr_in = 32'h0000_0102; rd_addr = 5'd6; rd_enable = 1'b1;
    @(negedge clk);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_noreq", {31'd0, ram_req}, 32'd0);
    check("mis_stall", {31'd0, stall_req}, 32'd0);
    check("mis_en", {31'd0, rd_enable_o}, 32'd0);
    next_cycle();
    idle_in();
    @(negedge clk);
    check("mis_flag_clear", {31'd0, misalign}, 32'd0);
    check("mis_noreq_after", {31'd0, ram_req}, 32'd0);
    next_cycle();
`else
    do_mem(EX_LW, 32'h0000_0102, 32'd0, 5'd6, 4, 1'b0, 32'h5AA5_1234, 1'b1, "lw_unaligned");
    // Address wrap-around: second byte lands at 0x00000000.
    do_mem(EX_SH, 32'hFFFF_FFFF, 32'h0000_A1B2, 5'd9, 2, 1'b1, 32'd0, 1'b0, "sh_wrap");
    check("wrap_mem3ff", {24'd0, mem[10'h3FF]}, 32'h0000_00B2);
    check("wrap_mem000", {24'd0, mem[10'h000]}, 32'h0000_00A1);
    check("misalign_tied", {31'd0, misalign}, 32'd0);
`endif

    check("ram_sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
